// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset PC, bubble word, widths and the
// IF/ID record that the ID/EX register reuses.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;

  localparam logic [WORD_W-1:0] PC_RESET_C = 32'h0000_3000;
  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_C      = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc8;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: holds on stall, jumps on a decode redirect,
// otherwise advances by one word with 32-bit wraparound.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc
);

  logic [WORD_W-1:0] pc_next;

  always_comb begin
    pc_next = pc + WORD_W'(4);
    if (stall) begin
      pc_next = pc;
    end else if (redirect) begin
      pc_next = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch plus IF/ID register. Define IF_STAGE_ADDR_CHECK_EN to add
// the alignment/range check and its fetch_exc_D output.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_C,
  parameter int                IM_WORDS = 4096,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush_D,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] im_addr,
  input  logic [WORD_W-1:0] im_rdata,
  output logic [WORD_W-1:0] IR_D,
  output logic [WORD_W-1:0] PC_D,
  output logic [WORD_W-1:0] PC8_D,
  output logic [IMM_W-1:0]  imm16_D,
  output logic              valid_D,
  output logic [WORD_W-1:0] fetch_cnt
`ifdef IF_STAGE_ADDR_CHECK_EN
  ,
  output logic              fetch_exc_D
`endif
);

  logic [WORD_W-1:0] pc_f;
  if_id_t            if_id;
  logic              fetch_ok;

  pc_reg #(
    .PC_RESET(PC_RESET)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc_f)
  );

  assign im_addr = pc_f;

`ifdef IF_STAGE_ADDR_CHECK_EN
  // 33-bit compare so a window ending at 2^32 does not overflow.
  localparam logic [WORD_W:0] IM_END = {1'b0, PC_RESET} + (WORD_W+1)'(4 * IM_WORDS);

  assign fetch_ok = (pc_f[1:0] == 2'b00)
                 && ({1'b0, pc_f} >= {1'b0, PC_RESET})
                 && ({1'b0, pc_f} <  IM_END);
`else
  logic unused_cfg;
  assign unused_cfg = (IM_WORDS > 0);
  assign fetch_ok   = 1'b1;
`endif

  // stall holds everything (redirect/flush are re-asserted by decode later);
  // flush_D or a rejected fetch loads a bubble that still records PC_F.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id     <= '{ir: NOP_WORD, pc: PC_RESET, pc8: PC_RESET + WORD_W'(8), valid: 1'b0};
      fetch_cnt <= '0;
`ifdef IF_STAGE_ADDR_CHECK_EN
      fetch_exc_D <= 1'b0;
`endif
    end else if (!stall) begin
      if (flush_D || !fetch_ok) begin
        if_id <= '{ir: NOP_WORD, pc: pc_f, pc8: pc_f + WORD_W'(8), valid: 1'b0};
      end else begin
        if_id <= '{ir: im_rdata, pc: pc_f, pc8: pc_f + WORD_W'(8), valid: 1'b1};
        if (fetch_cnt != '1) begin
          fetch_cnt <= fetch_cnt + WORD_W'(1);
        end
      end
`ifdef IF_STAGE_ADDR_CHECK_EN
      fetch_exc_D <= !flush_D && !fetch_ok;
`endif
    end
  end

  assign IR_D    = if_id.ir;
  assign PC_D    = if_id.pc;
  assign PC8_D   = if_id.pc8;
  assign valid_D = if_id.valid;
  assign imm16_D = if_id.ir[IMM_W-1:0];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the five-stage MIPS pipeline.
- Holds PC_F and addresses instruction memory (combinational read).
- Latches the fetched word into the decode-side register.
- Drives imm16_D (instr[15:0]) straight into the decode-stage 16→32 immediate extender, alongside IR_D/PC_D/PC8_D for decode, NPC and hazard logic.

Parameters:
- PC_RESET, 32'h0000_3000, PC_F value after reset.
- IM_WORDS, 4096, instruction-memory size in words; used by the optional range check.
- NOP_WORD, 32'h0000_0000, bubble encoding (sll $0,$0,0).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  from hazard unit: hold PC_F and the IF/ID register.
- flush_D  input  1  load a bubble into IF/ID this edge.
- redirect  input  1  from decode NPC logic: taken branch, j, jal, jr or jalr resolved in D.
- redirect_pc  input  32  target when redirect=1.
- im_addr  output  32  = PC_F, combinational.
- im_rdata  input  32  instruction word at im_addr, same cycle.
- IR_D  output  32  latched instruction.
- PC_D  output  32  PC of IR_D.
- PC8_D  output  32  PC_D+8, link address.
- imm16_D  output  16  IR_D[15:0], to the extender.
- valid_D  output  1  0 when IR_D is a bubble.
- fetch_cnt  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (clk edge with reset=1):
  - PC_F=PC_RESET.
  - IR_D=NOP_WORD, PC_D=PC_RESET, PC8_D=PC_RESET+8, valid_D=0, fetch_cnt=0.
  - reset overrides every other input, including mid-stall and mid-redirect.
- Next-PC priority, highest first:
  - stall: PC_F unchanged.
  - redirect: PC_F=redirect_pc.
  - otherwise PC_F+4.
  - PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- IF/ID update priority, highest first:
  - stall: hold all fields.
  - flush_D: IR_D=NOP_WORD, valid_D=0; PC_D/PC8_D take the current PC_F values for traceability.
  - otherwise IR_D=im_rdata, PC_D=PC_F, PC8_D=PC_F+8, valid_D=1, fetch_cnt+1.
- Branch delay slot: redirect does not squash the instruction being fetched. The delay-slot word enters IF/ID normally unless flush_D is also asserted.
- stall with redirect or flush_D: both are ignored that cycle. Decode re-asserts them while the stalled branch remains in D, so no target is lost.
- Latency:
  - instruction at PC_F appears on IR_D one edge later;
  - a redirect asserted in cycle n puts redirect_pc on im_addr in cycle n+1.
- imm16_D is purely IR_D[15:0], with no extra register stage. The extender's zero/sign-extension choice stays in decode.
- fetch_cnt saturates at 32'hFFFF_FFFF; it never wraps.
- im_addr low two bits are passed through unmodified; alignment is handled only by the optional feature.

Optional Feature:
- Macro: IF_STAGE_ADDR_CHECK_EN.
- Defined:
  - adds output fetch_exc_D (1 bit), reset 0;
  - a fetch with PC_F[1:0]!=0, or PC_F outside [PC_RESET, PC_RESET+4*IM_WORDS), loads IR_D=NOP_WORD, valid_D=0, fetch_exc_D=1, PC_D=PC_F;
  - fetch_cnt does not increment for such a fetch;
  - fetch_exc_D obeys the same stall/flush rules as IR_D.
- Undefined: no port, no check; im_rdata is latched for any PC.

Decomposition:
- Shared package mips_pkg holds:
  - PC_RESET_C=32'h0000_3000;
  - NOP_C;
  - width constants WORD_W=32 and IMM_W=16;
  - the IF/ID record typedef {ir, pc, pc8, valid}, reused by the ID/EX register.
- One natural sub-module: pc_reg, the PC register with the stall/redirect mux and +4 adder.
- The IF/ID latch and counter remain in if_stage.

Test Plan:
- Reset: assert reset 2 cycles, then release → im_addr=0x00003000, IR_D=0, valid_D=0; next edge, with im_rdata=0x2408FFFF → IR_D=0x2408FFFF, imm16_D=0xFFFF, PC8_D=0x00003008, fetch_cnt=1.
- Sequential: 4 free cycles → im_addr 0x3000, 0x3004, 0x3008, 0x300C; PC_D lags by one edge.
- Redirect with delay slot: redirect=1, redirect_pc=0x00003100 while PC_F=0x3008 → delay-slot word from 0x3008 enters IR_D; next im_addr=0x3100.
- Stall with redirect and flush: stall=1 plus redirect=1 and flush_D=1 for 2 cycles → PC_F, IR_D and fetch_cnt unchanged; after stall drops with redirect still high → PC_F=redirect_pc.
- Flush: flush_D=1 alone → IR_D=0, valid_D=0, fetch_cnt unchanged, PC still advances by 4.
- With IF_STAGE_ADDR_CHECK_EN: redirect_pc=0x00003002 → fetch_exc_D=1, IR_D=0; redirect_pc=0x00007000 (IM_WORDS=4096) → fetch_exc_D=1.
